imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the RV32I single-cycle core's instruction RAM: the writer side of the instruction-memory write port (`we`/`din`/address) that the core itself only reads. It accepts a byte stream (valid/ready), parses a 16-bit word-count header, assembles little-endian 32-bit instruction words and issues one write strobe per word at consecutive word addresses. It holds the core in reset while loading and releases it when the image is complete.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: instruction RAM depth in words; maximum accepted word count.
- `ADDR_W`, default 32: width of `mem_addr`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `start`  in  1  single-cycle pulse that restarts a load from DONE or ERR.
- `rx_valid`  in  1  byte available.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction RAM write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  byte address, always word-aligned (bits [1:0] = 0).
- `mem_wdata`  out  32  assembled instruction word.
- `core_reset`  out  1  reset to the core; high unless state is DONE.
- `busy`  out  1  high in LEN_LO, LEN_HI, DATA, WRITE, CSUM.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.

## Operation
- A byte is accepted on a cycle where `rx_valid && rx_ready`. `rx_data` is don't-care otherwise.
- Stream format: N[7:0], then N[15:8], then 4·N payload bytes, least-significant byte of each word first.
- States and transitions:
  - LEN_LO: accept a byte into N[7:0], then go to LEN_HI.
  - LEN_HI: accept a byte into N[15:8].
    - N == 0 or N > DEPTH_WORDS: go to ERR.
    - Otherwise: word index = 0, byte count = 0, go to DATA.
  - DATA: accept bytes into the word assembler. After the 4th byte, go to WRITE.
  - WRITE: `rx_ready` = 0. `mem_we` = 1, `mem_addr` = index·4, `mem_wdata` = assembled word. Increment the index.
    - Index + 1 == N: go to CSUM if enabled, otherwise DONE.
    - Otherwise: go back to DATA.
  - CSUM: described under Configuration.
  - DONE: `core_reset` = 0. A `start` pulse goes to LEN_LO and raises `core_reset` in the same transition.
  - ERR: `core_reset` held at 1. A `start` pulse goes to LEN_LO.
- `start` is ignored in every state except DONE and ERR.
- `rx_ready` = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in WRITE, DONE and ERR.
- Word index width is clog2(DEPTH_WORDS)+1. Address = {index, 2'b00}, zero-extended to ADDR_W. The index never wraps, because N ≤ DEPTH_WORDS is enforced before any write.
- RAM contents written before an ERR or a reset are not rolled back.

## Timing
- All outputs are registered. During and immediately after the reset cycle:
  - state = LEN_LO
  - `rx_ready` = 0 on the reset cycle, 1 from the following cycle
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `core_reset` = 1, `busy` = 1, `done` = 0, `error` = 0
- `mem_we` asserts on the cycle after the 4th byte of a word is accepted and lasts exactly one cycle. `mem_addr` and `mem_wdata` are stable while `mem_we` is high.
- Maximum throughput: 5 cycles per word (4 byte accepts plus 1 write cycle).
- `core_reset` falls on the cycle after the final write (or after the checksum byte when enabled).
- `reset` asserted mid-load: the partial word and the header are discarded, and the loader returns to LEN_LO on the next cycle.
- If `rx_valid` is held high through WRITE, no byte is lost: the byte stays unaccepted until DATA.

## Configuration
- Macro `IMEM_LOADER_CSUM_EN`.
- Defined:
  - After the last WRITE, the state is CSUM. It accepts one byte and compares it with the XOR of all 4·N payload bytes (header excluded).
  - Match: go to DONE. Mismatch: go to ERR.
  - The running XOR clears in LEN_LO.
- Undefined: no CSUM state and no XOR register. The last WRITE goes directly to DONE, and a trailing byte is not consumed.

## Structure
- Package `imem_loader_pkg`:
  - state enum `loader_state_t`: LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR
  - `LEN_BYTES` = 2
  - `WORD_BYTES` = 4
- One sub-module, `byte_word_packer`:
  - shifts accepted bytes into [31:24] while shifting the word right
  - 2-bit byte counter and a `word_full` flag
  - clear input driven by the FSM
- Top level contains the FSM, the word index, the header register and the optional XOR register.

## Test plan
- Header 0x02,0x00; payload 13 05 00 00, 93 05 10 00 → exactly two `mem_we` pulses:
  - addr 0x0, data 0x00000513
  - addr 0x4, data 0x00100593
  - then `done` = 1 and `core_reset` = 0 one cycle later.
- Header 0x00,0x00 → `error` = 1, `core_reset` stays 1, no `mem_we` pulse. Header 0x01,0x04 (N = 1025) → same result.
- `rx_valid` toggling randomly on a 3-word image → `mem_we` pulses at addr 0x0, 0x4, 0x8 with correct data. No byte is accepted on any WRITE cycle.
- `reset` pulsed after 2 payload bytes, then a fresh 1-word image 0x01,0x00,EF BE AD DE → single write of 0xDEADBEEF at addr 0x0.
- With `IMEM_LOADER_CSUM_EN`, 1-word image 0x11 0x22 0x33 0x44:
  - checksum byte 0x44 → DONE
  - checksum byte 0x45 → ERR
  - in both cases the write already occurred.
- After DONE, pulse `start` → `core_reset` = 1 on the next cycle and `busy` = 1. A second image then loads correctly from addr 0x0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum byte after the payload is enabled by IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // States in which a byte may be taken from the stream.
  function automatic logic rx_open(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles little-endian 32-bit words from an accepted byte stream.
// Each byte enters at [31:24] while the word shifts right, so after four
// bytes the first byte sits in [7:0].
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift in accepted bytes; the counter wraps to 0 after the last byte of a word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept_i) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Word and byte-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: parses a 16-bit word-count header, writes 32-bit
// little-endian words to consecutive word addresses and holds the core in
// reset until the image is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
  localparam int LEN_W = 8 * LEN_BYTES;

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rx_ready_q, rx_ready_d;
  logic             mem_we_q, mem_we_d;
  logic             core_reset_q, core_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             accept;
  logic             pack_clear;
  logic             word_full;
  logic [31:0]      word;
  logic [LEN_W-1:0] hdr_len;

  // rx_ready is a registered copy of the state's readiness, so handshake
  // decisions use the flop rather than the next-state logic.
  assign accept     = rx_valid && rx_ready_q;
  assign hdr_len    = {rx_data, len_q[7:0]};
  assign pack_clear = (state_q == LEN_LO) || (state_q == LEN_HI);

  byte_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pack_clear),
    .accept_i    (accept && (state_q == DATA)),
    .byte_i      (rx_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] xor_q, xor_d;

  // Running XOR over payload bytes only; the header never contributes.
  always_comb begin
    xor_d = xor_q;
    if (state_q == LEN_LO)
      xor_d = '0;
    else if ((state_q == DATA) && accept)
      xor_d = xor_q ^ rx_data;
  end

  // Checksum accumulator register.
  always_ff @(posedge clk) begin
    if (reset) xor_q <= '0;
    else       xor_q <= xor_d;
  end
`endif

  // Next-state, header/index updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[LEN_W-1:8], rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = hdr_len;
          if ((hdr_len == '0) || (32'(hdr_len) > 32'(DEPTH_WORDS))) begin
            state_d = ERR;
          end else begin
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if ((32'(idx_q) + 32'd1) == 32'(len_q)) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) state_d = (rx_data == xor_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        if (start) state_d = LEN_LO;
      end
      ERR: begin
        if (start) state_d = LEN_LO;
      end
      default: state_d = LEN_LO;
    endcase

    rx_ready_d   = rx_open(state_d);
    mem_we_d     = (state_d == WRITE);
    core_reset_d = (state_d != DONE);
    busy_d       = rx_open(state_d) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
  end

  // State, header, index and output registers; rx_ready stays low on the
  // cycle following reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LEN_LO;
      len_q        <= '0;
      idx_q        <= '0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = ADDR_W'({idx_q, 2'b00});
  assign mem_wdata  = word;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes come from the image
// itself (word i at byte address 4*i); the expected checksum is the XOR of
// the payload bytes. Build with IMEM_LOADER_CSUM_EN to cover the checksum path.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, core_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] img_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture every write strobe; no byte may be taken while a write is in progress.
  always @(negedge clk) begin
    if (reset === 1'b0 && mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      chk("ready_in_write", 64'(rx_ready), 64'd0);
      chk("addr_align", 64'(mem_addr[1:0]), 64'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_status(output int t);
    t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("status_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_core_reset", 64'(core_reset), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_error", 64'(error), 64'd0);
  endtask

  task automatic run_image(input bit gaps, input bit bad_csum);
    logic [15:0] n;
    logic [7:0]  xs, bv;
    logic        exp_ok;
    int          t, exp_t, nw;
    n  = 16'(img_q.size());
    xs = 8'h00;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    foreach (img_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        bv = img_q[i][8*k +: 8];
        xs ^= bv;
        send_byte(bv, gaps);
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(bad_csum ? (xs ^ 8'h01) : xs, gaps);
    exp_t = 0;
`else
    exp_t = 1;
`endif
    exp_ok = !bad_csum;
    wait_status(t);
    #1;
    chk("status_latency", 64'(t), 64'(exp_t));
    chk("img_done", 64'(done), 64'(exp_ok));
    chk("img_error", 64'(error), 64'(!exp_ok));
    chk("img_core_reset", 64'(core_reset), 64'(!exp_ok));
    chk("img_busy", 64'(busy), 64'd0);
    chk("wr_count", 64'(wr_addr_q.size()), 64'(n));
    nw = (wr_addr_q.size() < img_q.size()) ? wr_addr_q.size() : img_q.size();
    for (int i = 0; i < nw; i++) begin
      chk("wr_addr", 64'(wr_addr_q[i]), 64'(4 * i));
      chk("wr_data", 64'(wr_data_q[i]), 64'(img_q[i]));
    end
  endtask

  task automatic run_bad_header(input logic [7:0] lo, input logic [7:0] hi);
    int t;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    wait_status(t);
    repeat (3) @(negedge clk);
    chk("hdr_error", 64'(error), 64'd1);
    chk("hdr_done", 64'(done), 64'd0);
    chk("hdr_core_reset", 64'(core_reset), 64'd1);
    chk("hdr_no_write", 64'(wr_addr_q.size()), 64'd0);
    pulse_start();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);

    // Two-word directed image.
    img_q = '{32'h0000_0513, 32'h0010_0593};
    run_image(1'b0, 1'b0);

`ifndef IMEM_LOADER_CSUM_EN
    // A trailing byte after the image must stay unconsumed.
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("trail_ready", 64'(rx_ready), 64'd0);
      chk("trail_done", 64'(done), 64'd1);
    end
    rx_valid = 1'b0;
`endif
    pulse_start();

    // Header length limits.
    run_bad_header(8'h00, 8'h00);
    run_bad_header(8'h01, 8'h04);

    // Three random words with rx_valid toggling.
    img_q = '{$urandom, $urandom, $urandom};
    run_image(1'b1, 1'b0);
    pulse_start();

    // Reset in the middle of a word discards header and partial word.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd1);
    chk("midrst_rx_ready", 64'(rx_ready), 64'd0);
    img_q = '{32'hDEAD_BEEF};
    run_image(1'b0, 1'b0);
    pulse_start();

    // Random image sizes, including the back-to-back restart path.
    for (int r = 0; r < 4; r++) begin
      img_q.delete();
      repeat ($urandom_range(1, 8)) img_q.push_back($urandom);
      run_image(1'(r & 1), 1'b0);
      pulse_start();
    end

`ifdef IMEM_LOADER_CSUM_EN
    img_q = '{32'h4433_2211};
    run_image(1'b0, 1'b0);
    pulse_start();
    run_image(1'b0, 1'b1);
    pulse_start();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
